// File: rtl/jelly_axi4_pattern_master_if.sv
// AXI4 master-side bundle for the pattern master (AW/W/B/AR/R channels).
// No logic, no latency: pure signal grouping with master/slave views.
// Backpressure is carried by the ready/valid pairs of each channel.
interface jelly_axi4_pattern_master_if #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_SIZE  = 3,
  parameter int AXI_LEN_WIDTH  = 8
);
  localparam int DATA_WIDTH = 8 << AXI_DATA_SIZE;
  localparam int STRB_WIDTH = 1 << AXI_DATA_SIZE;

  logic [AXI_ID_WIDTH-1:0]   awid;
  logic [AXI_ADDR_WIDTH-1:0] awaddr;
  logic [AXI_LEN_WIDTH-1:0]  awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic [3:0]                awqos;
  logic                      awvalid;
  logic                      awready;

  logic [DATA_WIDTH-1:0]     wdata;
  logic [STRB_WIDTH-1:0]     wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;

  logic [AXI_ID_WIDTH-1:0]   bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  logic [AXI_ID_WIDTH-1:0]   arid;
  logic [AXI_ADDR_WIDTH-1:0] araddr;
  logic [AXI_LEN_WIDTH-1:0]  arlen;
  logic [2:0]                arsize;
  logic [1:0]                arburst;
  logic                      arlock;
  logic [3:0]                arcache;
  logic [2:0]                arprot;
  logic [3:0]                arqos;
  logic                      arvalid;
  logic                      arready;

  logic [AXI_ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rlast;
  logic                      rvalid;
  logic                      rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/jelly_axi4_pattern_master.sv
// Writes a beat-counter pattern over burst_num INCR bursts, reads it back, counts faults.
// awvalid/busy rise on the edge that accepts start; done pulses one cycle after the last R beat.
// One burst in flight; every valid and payload is registered and held until its ready.
module jelly_axi4_pattern_master #(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_SIZE  = 3,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr,
  input  logic [AXI_LEN_WIDTH-1:0]  burst_len,
  input  logic [COUNT_WIDTH-1:0]    burst_num,
  output logic                      busy,
  output logic                      done,
  output logic [COUNT_WIDTH-1:0]    error_count,
  jelly_axi4_pattern_master_if.master m_axi4
);
  localparam int DATA_WIDTH = 8 << AXI_DATA_SIZE;
  localparam int LANES      = DATA_WIDTH / 32;

  typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_AR, ST_R, ST_DONE} state_t;

  state_t                    r_state;
  logic                      r_busy, r_done;
  logic [COUNT_WIDTH-1:0]    r_err, r_num, r_n, r_k;
  logic [AXI_ADDR_WIDTH-1:0] r_base;
  logic [AXI_LEN_WIDTH-1:0]  r_len, r_beat;
  logic                      r_awvalid, r_wvalid, r_wlast, r_bready, r_arvalid, r_rready;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [AXI_LEN_WIDTH-1:0]  r_awlen, r_arlen;
  logic [DATA_WIDTH-1:0]     r_wdata;

  logic [AXI_ADDR_WIDTH-1:0] w_burst_bytes;
  logic [COUNT_WIDTH-1:0]    w_k_next, w_n_next;
  logic [AXI_LEN_WIDTH-1:0]  w_beat_next;
  logic                      w_last_beat, w_err_b, w_err_r, w_err_hit;

  // Every 32-bit lane carries the global beat index.
  function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [COUNT_WIDTH-1:0] k);
    return {LANES{32'(k)}};
  endfunction

  assign w_burst_bytes = (AXI_ADDR_WIDTH'(r_len) + AXI_ADDR_WIDTH'(1)) << AXI_DATA_SIZE;
  assign w_k_next      = r_k + 1'b1;
  assign w_n_next      = r_n + 1'b1;
  assign w_beat_next   = r_beat + 1'b1;
  assign w_last_beat   = (r_beat == r_len);

  // Several faults on one beat collapse into a single increment.
  assign w_err_b   = (m_axi4.bresp != 2'b00);
  assign w_err_r   = (m_axi4.rdata != f_pattern(r_k)) || (m_axi4.rresp != 2'b00) ||
                     (m_axi4.rlast != w_last_beat);
  assign w_err_hit = ((r_state == ST_B) && r_bready && m_axi4.bvalid && w_err_b) ||
                     ((r_state == ST_R) && r_rready && m_axi4.rvalid && w_err_r);

  // Sequencer: write phase, then read-and-compare phase, one burst at a time.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= ST_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= '0;
      r_num     <= '0;
      r_n       <= '0;
      r_k       <= '0;
      r_base    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_wvalid  <= 1'b0;
      r_wdata   <= '0;
      r_wlast   <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_rready  <= 1'b0;
    end else begin
      if (w_err_hit && !(&r_err)) r_err <= r_err + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start && !r_done) begin
            r_base <= base_addr;
            r_len  <= burst_len;
            r_num  <= burst_num;
            r_err  <= '0;
            r_n    <= '0;
            r_k    <= '0;
            r_busy <= 1'b1;
            if (burst_num == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_awvalid <= 1'b1;
              r_awaddr  <= base_addr;
              r_awlen   <= burst_len;
              r_state   <= ST_AW;
            end
          end
        end
        ST_AW: if (m_axi4.awready) begin
          r_awvalid <= 1'b0;
          r_wvalid  <= 1'b1;
          r_wdata   <= f_pattern(r_k);
          r_wlast   <= (r_len == '0);
          r_beat    <= '0;
          r_state   <= ST_W;
        end
        ST_W: if (m_axi4.wready) begin
          r_k <= w_k_next;
          if (r_wlast) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
            r_bready <= 1'b1;
            r_state  <= ST_B;
          end else begin
            r_beat  <= w_beat_next;
            r_wdata <= f_pattern(w_k_next);
            r_wlast <= (w_beat_next == r_len);
          end
        end
        ST_B: if (m_axi4.bvalid) begin
          r_bready <= 1'b0;
          if (w_n_next == r_num) begin
            r_n       <= '0;
            r_k       <= '0;
            r_arvalid <= 1'b1;
            r_araddr  <= r_base;
            r_arlen   <= r_len;
            r_state   <= ST_AR;
          end else begin
            r_n       <= w_n_next;
            r_awvalid <= 1'b1;
            r_awaddr  <= r_awaddr + w_burst_bytes;
            r_state   <= ST_AW;
          end
        end
        ST_AR: if (m_axi4.arready) begin
          r_arvalid <= 1'b0;
          r_rready  <= 1'b1;
          r_beat    <= '0;
          r_state   <= ST_R;
        end
        ST_R: if (m_axi4.rvalid) begin
          r_k    <= w_k_next;
          r_beat <= w_beat_next;
          // The burst ends on the expected last beat whatever rlast says.
          if (w_last_beat) begin
            r_rready <= 1'b0;
            r_n      <= w_n_next;
            if (w_n_next == r_num) begin
              r_state <= ST_DONE;
            end else begin
              r_arvalid <= 1'b1;
              r_araddr  <= r_araddr + w_burst_bytes;
              r_state   <= ST_AR;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign error_count = r_err;

  assign m_axi4.awid    = '0;
  assign m_axi4.awaddr  = r_awaddr;
  assign m_axi4.awlen   = r_awlen;
  assign m_axi4.awsize  = 3'(AXI_DATA_SIZE);
  assign m_axi4.awburst = 2'b01;
  assign m_axi4.awlock  = 1'b0;
  assign m_axi4.awcache = 4'b0011;
  assign m_axi4.awprot  = 3'b000;
  assign m_axi4.awqos   = 4'b0000;
  assign m_axi4.awvalid = r_awvalid;
  assign m_axi4.wdata   = r_wdata;
  assign m_axi4.wstrb   = '1;
  assign m_axi4.wlast   = r_wlast;
  assign m_axi4.wvalid  = r_wvalid;
  assign m_axi4.bready  = r_bready;
  assign m_axi4.arid    = '0;
  assign m_axi4.araddr  = r_araddr;
  assign m_axi4.arlen   = r_arlen;
  assign m_axi4.arsize  = 3'(AXI_DATA_SIZE);
  assign m_axi4.arburst = 2'b01;
  assign m_axi4.arlock  = 1'b0;
  assign m_axi4.arcache = 4'b0011;
  assign m_axi4.arprot  = 3'b000;
  assign m_axi4.arqos   = 4'b0000;
  assign m_axi4.arvalid = r_arvalid;
  assign m_axi4.rready  = r_rready;
endmodule

// File: tb/tb_jelly_axi4_pattern_master.sv
`timescale 1ns/1ps
// Bench for the AXI4 pattern master: memory-backed slave with random readiness,
// a reference model that precomputes the expected AW/W/AR traffic and error count,
// and a monitor that pops and compares at every handshake.
module tb_jelly_axi4_pattern_master;
  typedef struct { logic [31:0] addr; logic [7:0] len; } req_t;
  typedef struct { logic [63:0] data; logic last; } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] base_addr;
  logic [7:0]  burst_len;
  logic [15:0] burst_num;
  logic        busy, done;
  logic [15:0] error_count;

  always #5 clk = ~clk;

  jelly_axi4_pattern_master_if #(.AXI_ID_WIDTH(6), .AXI_ADDR_WIDTH(32), .AXI_DATA_SIZE(3),
                                 .AXI_LEN_WIDTH(8)) axi ();

  jelly_axi4_pattern_master #(.AXI_ID_WIDTH(6), .AXI_ADDR_WIDTH(32), .AXI_DATA_SIZE(3),
                              .AXI_LEN_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .aclk(clk), .aresetn(rst_n), .start(start), .base_addr(base_addr),
    .burst_len(burst_len), .burst_num(burst_num), .busy(busy), .done(done),
    .error_count(error_count), .m_axi4(axi));

  int n_tests = 0, n_fail = 0;
  int busy_pct = 0, aw_delay = 0, corrupt_k = -1, rresp_k = -1, exp_err = 0;
  req_t  exp_aw[$], exp_ar[$], aw_log[$], rd_q[$];
  beat_t exp_w[$], w_log[$], ref_log[$];
  logic [63:0] mem [int];

  // slave/monitor state
  bit    hs_aw, hs_w, hs_b, hs_ar, hs_r, vld_seen;
  bit    prev_awv, prev_wv, prev_arv;
  req_t  cap_aw, cap_ar, prev_aw, prev_ar;
  beat_t cap_w, prev_w;
  logic [31:0] wr_ptr, ra;
  int    b_pend, aw_wait, ar_wait, r_beat, rd_k, aw_hs_total;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name, input logic [63:0] info);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event (info %0h)", name, info);
  endtask

  function automatic bit go();
    return $urandom_range(0, 99) >= busy_pct;
  endfunction

  function automatic logic [63:0] pattern(input int k);
    logic [63:0] p;
    for (int lane = 0; lane < 2; lane++) p[lane*32 +: 32] = k[31:0];
    return p;
  endfunction

  task automatic slave_clear();
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
    axi.rvalid = 0; axi.rresp = 0; axi.rid = 0; axi.rdata = 0; axi.rlast = 0;
    hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
    prev_awv = 0; prev_wv = 0; prev_arv = 0;
    rd_q.delete();
    b_pend = 0; aw_wait = 0; ar_wait = 0; r_beat = 0; rd_k = 0;
  endtask

  // Slave model and monitor. At each falling edge: apply the handshakes that
  // completed on the rising edge just passed, choose new ready/valid values,
  // then work out which handshakes the coming rising edge will complete.
  initial begin
    slave_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slave_clear();
        continue;
      end
      if (hs_aw) begin wr_ptr = cap_aw.addr; aw_wait = 0; end
      if (hs_w) begin
        mem[int'(wr_ptr >> 3)] = cap_w.data;
        wr_ptr = wr_ptr + 32'd8;
        if (cap_w.last) b_pend++;
      end
      if (hs_b) begin axi.bvalid = 0; b_pend--; end
      if (hs_ar) begin rd_q.push_back(cap_ar); ar_wait = 0; end
      if (hs_r) begin
        axi.rvalid = 0;
        rd_k++;
        if (r_beat == int'(rd_q[0].len)) begin rd_q.delete(0); r_beat = 0; end
        else r_beat++;
      end

      if (axi.awvalid) aw_wait++;
      if (axi.arvalid) ar_wait++;
      axi.awready = axi.awvalid && (aw_wait > aw_delay) && go();
      axi.arready = axi.arvalid && (ar_wait > aw_delay) && go();
      axi.wready  = go();
      if (!axi.bvalid && b_pend > 0 && go()) begin axi.bvalid = 1; axi.bresp = 2'b00; end
      if (!axi.rvalid && rd_q.size() > 0 && go()) begin
        ra = rd_q[0].addr + 32'(r_beat * 8);
        axi.rdata = mem.exists(int'(ra >> 3)) ? mem[int'(ra >> 3)] : 64'h0;
        if (rd_k == corrupt_k) axi.rdata = axi.rdata ^ 64'h100;
        axi.rresp  = (rd_k == rresp_k) ? 2'b10 : 2'b00;
        axi.rlast  = (r_beat == int'(rd_q[0].len));
        axi.rvalid = 1;
      end

      if (prev_awv && !hs_aw)
        check("aw_hold", {axi.awvalid, axi.awlen, axi.awaddr}, {1'b1, prev_aw.len, prev_aw.addr});
      if (prev_wv && !hs_w)
        check("w_hold", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, prev_w.last, prev_w.data});
      if (prev_arv && !hs_ar)
        check("ar_hold", {axi.arvalid, axi.arlen, axi.araddr}, {1'b1, prev_ar.len, prev_ar.addr});
      if (axi.awvalid || axi.wvalid || axi.arvalid) vld_seen = 1;

      hs_aw = axi.awvalid && axi.awready;
      hs_w  = axi.wvalid && axi.wready;
      hs_b  = axi.bvalid && axi.bready;
      hs_ar = axi.arvalid && axi.arready;
      hs_r  = axi.rvalid && axi.rready;

      if (hs_aw) begin
        cap_aw = '{axi.awaddr, axi.awlen};
        aw_log.push_back(cap_aw);
        aw_hs_total++;
        check("aw_fields", {axi.awid, axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot, axi.awqos},
              {6'd0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
        if (exp_aw.size() == 0) note_fail("aw_extra", {32'h0, cap_aw.addr});
        else begin
          req_t e;
          e = exp_aw.pop_front();
          check("aw_req", {cap_aw.len, cap_aw.addr}, {e.len, e.addr});
        end
      end
      if (hs_w) begin
        cap_w = '{axi.wdata, axi.wlast};
        w_log.push_back(cap_w);
        check("w_strb", axi.wstrb, 8'hFF);
        if (exp_w.size() == 0) note_fail("w_extra", cap_w.data);
        else begin
          beat_t e;
          e = exp_w.pop_front();
          check("w_beat", {cap_w.last, cap_w.data}, {e.last, e.data});
        end
      end
      if (hs_ar) begin
        cap_ar = '{axi.araddr, axi.arlen};
        check("ar_fields", {axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot, axi.arqos},
              {6'd0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
        if (exp_ar.size() == 0) note_fail("ar_extra", {32'h0, cap_ar.addr});
        else begin
          req_t e;
          e = exp_ar.pop_front();
          check("ar_req", {cap_ar.len, cap_ar.addr}, {e.len, e.addr});
        end
      end

      prev_awv = axi.awvalid; prev_aw = '{axi.awaddr, axi.awlen};
      prev_wv  = axi.wvalid;  prev_w  = '{axi.wdata, axi.wlast};
      prev_arv = axi.arvalid; prev_ar = '{axi.araddr, axi.arlen};
    end
  end

  // Reference model: expected traffic and error count from the pattern rules.
  task automatic model_run(input logic [31:0] base, input logic [7:0] len, input logic [15:0] num);
    int k;
    k = 0;
    exp_err = 0;
    for (int n = 0; n < int'(num); n++) begin
      exp_aw.push_back('{base + 32'(n * (int'(len) + 1) * 8), len});
      exp_ar.push_back('{base + 32'(n * (int'(len) + 1) * 8), len});
      for (int i = 0; i <= int'(len); i++) begin
        exp_w.push_back('{pattern(k), i == int'(len)});
        k++;
      end
    end
    for (int j = 0; j < k; j++) if (j == corrupt_k || j == rresp_k) exp_err++;
  endtask

  task automatic clear_expect();
    exp_aw.delete(); exp_w.delete(); exp_ar.delete();
  endtask

  task automatic dut_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    clear_expect();
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic issue_start(input logic [31:0] base, input logic [7:0] len, input logic [15:0] num);
    w_log.delete(); aw_log.delete(); aw_hs_total = 0; rd_k = 0;
    @(negedge clk);
    base_addr = base; burst_len = len; burst_num = num; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin @(negedge clk); c++; end
    if (!done) begin
      note_fail("done_timeout", 64'(c));
      dut_reset();
    end
  endtask

  task automatic run(input logic [31:0] base, input logic [7:0] len, input logic [15:0] num,
                     input bit extra_start);
    model_run(base, len, num);
    issue_start(base, len, num);
    check("start_latency", {busy, axi.awvalid}, 2'b11);
    if (extra_start) begin
      repeat (4) @(negedge clk);
      base_addr = 32'hDEAD_0000; start = 1;
      @(negedge clk);
      start = 0;
    end
    wait_done(20000);
    check("error_count", error_count, 16'(exp_err));
    check("expect_left", exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
  endtask

  initial begin
    int busy_cyc, done_at, mism, nlast, c;
    logic [31:0] seq_addr [4];
    rst_n = 0; start = 0; base_addr = 0; burst_len = 0; burst_num = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, error_count, axi.awvalid, axi.wvalid, axi.wlast,
                         axi.bready, axi.arvalid, axi.rready}, 0);
    check("reset_addr", {axi.awaddr, axi.awlen, axi.araddr, axi.arlen}, 0);
    check("reset_wdata", axi.wdata, 0);
    rst_n = 1;
    @(negedge clk);

    // 4 x 16-beat bursts at 0x1000, slave always ready
    run(32'h1000, 8'd15, 16'd4, 0);
    seq_addr = '{32'h1000, 32'h1080, 32'h1100, 32'h1180};
    check("aw_count", aw_log.size(), 4);
    for (int i = 0; i < 4 && i < aw_log.size(); i++) check("aw_seq", aw_log[i].addr, seq_addr[i]);
    check("w_count", w_log.size(), 64);
    if (w_log.size() > 17) check("w_beat17", w_log[17].data, 64'h00000011_00000011);
    else note_fail("w_beat17_missing", 64'(w_log.size()));
    ref_log = w_log;
    // start while done is high must be ignored
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    check("start_during_done", {busy, axi.awvalid}, 2'b00);
    check("err_hold", error_count, 0);

    // same transfer with a busy slave and slow address channels
    busy_pct = 50; aw_delay = 20;
    run(32'h1000, 8'd15, 16'd4, 1);
    mism = 0;
    for (int i = 0; i < w_log.size() && i < ref_log.size(); i++)
      if (w_log[i] != ref_log[i]) mism++;
    check("wlog_size_same", w_log.size(), ref_log.size());
    check("wlog_same", mism, 0);
    busy_pct = 0; aw_delay = 0;

    // burst_num = 0: no traffic, short busy, quick done
    vld_seen = 0;
    model_run(32'h3000, 8'd5, 16'd0);
    issue_start(32'h3000, 8'd5, 16'd0);
    busy_cyc = 0; done_at = 0;
    for (int i = 1; i <= 6; i++) begin
      if (busy) busy_cyc++;
      if (done && done_at == 0) done_at = i;
      @(negedge clk);
    end
    check("n0_done_latency", (done_at >= 1 && done_at <= 3), 1);
    check("n0_busy_len", (busy_cyc >= 1 && busy_cyc <= 2), 1);
    check("n0_no_valid", vld_seen, 0);
    check("n0_err", error_count, 0);

    // read corruption on beat 5 and SLVERR on beat 9
    corrupt_k = 5; rresp_k = 9;
    run(32'h4000, 8'd7, 16'd2, 0);
    corrupt_k = -1; rresp_k = -1;

    // reset while writing burst 2
    busy_pct = 30;
    model_run(32'h2000, 8'd15, 16'd4);
    issue_start(32'h2000, 8'd15, 16'd4);
    c = 0;
    while (!(aw_hs_total >= 3 && axi.wvalid) && c < 3000) begin @(negedge clk); c++; end
    check("reach_burst2_w", (aw_hs_total >= 3 && axi.wvalid), 1);
    #1 rst_n = 0;
    #1 check("reset_async", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready, busy}, 0);
    repeat (3) @(negedge clk);
    clear_expect();
    rst_n = 1;
    @(negedge clk);
    run(32'h2000, 8'd15, 16'd4, 0);
    busy_pct = 0;

    // single-beat bursts
    run(32'h5000, 8'd0, 16'd3, 0);
    nlast = 0;
    foreach (w_log[i]) if (w_log[i].last) nlast++;
    check("len0_wlast", nlast, 3);
    check("len0_aw_count", aw_log.size(), 3);
    for (int i = 0; i < 3 && i < aw_log.size(); i++)
      check("len0_addr", aw_log[i].addr, 32'h5000 + 32'(i * 8));

    // random shapes and slave behaviour
    for (int r = 0; r < 4; r++) begin
      busy_pct = $urandom_range(0, 60);
      aw_delay = $urandom_range(0, 5);
      run({12'h0, 8'($urandom_range(0, 255)), 12'h0}, 8'($urandom_range(0, 15)),
          16'($urandom_range(1, 6)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
